// File: rtl/audio_mixer_seq.sv
// ---------------------------------------------------------------------------
// audio_mixer_seq
// Stereo voice mixer with per-voice gain/pan/enable, time-multiplexed MAC
// (one voice per clock), master volume, clip handling and sticky status.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_clk_en         one-cycle frame strobe
//   wb_cyc_i .. wb_ack_o  Wishbone slave (byte address, [7:2] decoded)
//   voice_in              packed signed voices, voice i at [i*SAMPLE_W +: SAMPLE_W]
//   audio_left/right      signed mixed outputs, held between out_valid pulses
//   out_valid             one-cycle pulse when new outputs are presented
//   busy                  high while a frame is in flight
// ---------------------------------------------------------------------------
module audio_mixer_seq #(
   parameter int NUM_VOICES = 8,
   parameter int SAMPLE_W   = 16,
   parameter int ACC_W      = SAMPLE_W + 6
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sample_clk_en,
   input  logic                           wb_cyc_i,
   input  logic                           wb_stb_i,
   input  logic                           wb_we_i,
   input  logic [31:0]                    wb_adr_i,
   input  logic [31:0]                    wb_dat_i,
   output logic [31:0]                    wb_dat_o,
   output logic                           wb_ack_o,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
   output logic signed [SAMPLE_W-1:0]     audio_left,
   output logic signed [SAMPLE_W-1:0]     audio_right,
   output logic                           out_valid,
   output logic                           busy
);

   localparam int PROD_W = SAMPLE_W + 10;   // sample * {0,gain}
   localparam int MIX_W  = PROD_W + 10;     // p * pan weight
   localparam int SCL_W  = ACC_W + 17;      // acc * {0,master}

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;
   state_t state_reg, state_next;

   // ---------------- configuration registers ----------------
   logic [1:0]  ctrl_reg;
   logic [15:0] master_reg;
   logic [2:0]  status_reg;
   logic [1:0]  clip_mode_reg;
   logic [8:0]  gain_arr [NUM_VOICES];
   logic [8:0]  pan_arr  [NUM_VOICES];
   logic        en_arr   [NUM_VOICES];
   logic [31:0] cfg_rd   [NUM_VOICES];

   // ---------------- Wishbone ----------------
   logic        req;
   logic [5:0]  adr_idx;
   logic [31:0] rd_data;
   logic        wr_pend_reg;
   logic [5:0]  wr_idx_reg;
   logic [31:0] wr_dat_reg;
   logic        commit;

   assign adr_idx = wb_adr_i[7:2];
   // Excluding the ack cycle gives the mandatory idle cycle between acks.
   assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign commit  = wb_ack_o & wr_pend_reg;

   always_comb begin
      rd_data = 32'hDEAD_BEEF;
      case (adr_idx)
         6'd0:    rd_data = {30'd0, ctrl_reg};
         6'd1:    rd_data = {16'd0, master_reg};
         6'd2:    rd_data = {29'd0, status_reg};
         6'd3:    rd_data = {30'd0, clip_mode_reg};
         default: ;
      endcase
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (adr_idx == 6'(16 + i)) rd_data = cfg_rd[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
         wr_pend_reg <= 1'b0;
         wr_idx_reg  <= '0;
         wr_dat_reg  <= '0;
      end else begin
         wb_ack_o <= req;
         if (req) begin
            wb_dat_o    <= rd_data;
            wr_pend_reg <= wb_we_i;
            wr_idx_reg  <= adr_idx;
            wr_dat_reg  <= wb_dat_i;
         end
      end
   end

   // ---------------- global registers ----------------
   logic [2:0] status_set, status_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_reg      <= 2'b01;
         master_reg    <= 16'h8000;
         clip_mode_reg <= 2'd1;
      end else if (commit) begin
         case (wr_idx_reg)
            6'd0:    ctrl_reg      <= wr_dat_reg[1:0];
            6'd1:    master_reg    <= wr_dat_reg[15:0];
            6'd3:    clip_mode_reg <= wr_dat_reg[1:0];
            default: ;
         endcase
      end
   end

   assign status_clr = (commit && wr_idx_reg == 6'd2) ? wr_dat_reg[2:0] : 3'd0;

   // Sticky bits: a new event in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) status_reg <= '0;
      else        status_reg <= (status_reg & ~status_clr) | status_set;
   end

   // ---------------- per-voice configuration ----------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         logic [8:0] gain_reg, pan_reg;
         logic       en_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               gain_reg <= 9'h100;
               pan_reg  <= 9'h080;
               en_reg   <= 1'b1;
            end else if (commit && wr_idx_reg == 6'(16 + gi)) begin
               gain_reg <= wr_dat_reg[8:0];
               pan_reg  <= (wr_dat_reg[24:16] > 9'h100) ? 9'h100 : wr_dat_reg[24:16];
               en_reg   <= wr_dat_reg[31];
            end
         end
         assign gain_arr[gi] = gain_reg;
         assign pan_arr[gi]  = pan_reg;
         assign en_arr[gi]   = en_reg;
         assign cfg_rd[gi]   = {en_reg, 6'd0, pan_reg, 7'd0, gain_reg};
      end
   endgenerate

   // ---------------- frame sequencer ----------------
   logic [NUM_VOICES*SAMPLE_W-1:0] hold_reg;
   logic signed [ACC_W-1:0]        acc_l_reg, acc_r_reg;
   logic [4:0]                     v_reg;
   logic                           start, overrun_set;

   assign start       = (state_reg == IDLE) & sample_clk_en & ctrl_reg[0];
   assign overrun_set = (state_reg != IDLE) & sample_clk_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE:    if (start) state_next = ACCUM;
         ACCUM:   if (v_reg == 5'(NUM_VOICES - 1)) state_next = SCALE;
         SCALE:   state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Live config lookup for the voice being accumulated this cycle.
   logic signed [SAMPLE_W-1:0] s_sel;
   logic [8:0]                 gain_sel, pan_sel;
   logic                       en_sel;

   always_comb begin
      s_sel    = '0;
      gain_sel = '0;
      pan_sel  = '0;
      en_sel   = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (v_reg == 5'(i)) begin
            s_sel    = hold_reg[i*SAMPLE_W +: SAMPLE_W];
            gain_sel = gain_arr[i];
            pan_sel  = pan_arr[i];
            en_sel   = en_arr[i];
         end
      end
   end

   logic signed [PROD_W-1:0] p_full;
   logic [9:0]               w_left, w_right;
   logic signed [MIX_W-1:0]  l_term, r_term;

   assign p_full  = (PROD_W'(s_sel) * PROD_W'($signed({1'b0, gain_sel}))) >>> 8;
   assign w_left  = 10'h100 - {1'b0, pan_sel};
   assign w_right = {1'b0, pan_sel};
   assign l_term  = (MIX_W'(p_full) * MIX_W'($signed(w_left)))  >>> 8;
   assign r_term  = (MIX_W'(p_full) * MIX_W'($signed(w_right))) >>> 8;

   // ---------------- master volume and clipping ----------------
   logic signed [SCL_W-1:0] y_l, y_r;
   logic [SAMPLE_W:0]       res_l, res_r;   // {clipped, sample}

   assign y_l = (SCL_W'(acc_l_reg) * SCL_W'($signed({1'b0, master_reg}))) >>> 15;
   assign y_r = (SCL_W'(acc_r_reg) * SCL_W'($signed({1'b0, master_reg}))) >>> 15;

   function automatic logic [SAMPLE_W:0] clip_fn(input logic signed [SCL_W-1:0] y,
                                                 input logic [1:0] mode);
      logic             ovf;
      logic [SAMPLE_W-1:0] sat;
      // Fits iff all bits from the output sign bit upward agree.
      ovf = !((&y[SCL_W-1:SAMPLE_W-1]) || !(|y[SCL_W-1:SAMPLE_W-1]));
      sat = y[SCL_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
      case (mode)
         2'd0:    clip_fn = {1'b0, y[SAMPLE_W-1:0]};
         2'd1:    clip_fn = ovf ? {1'b1, sat} : {1'b0, y[SAMPLE_W-1:0]};
         default: clip_fn = '0;
      endcase
   endfunction

   assign res_l = clip_fn(y_l, clip_mode_reg);
   assign res_r = clip_fn(y_r, clip_mode_reg);

   // Mute suppresses both the sample and the clip report.
   assign status_set = {overrun_set,
                        (state_reg == SCALE) & ~ctrl_reg[1] & res_r[SAMPLE_W],
                        (state_reg == SCALE) & ~ctrl_reg[1] & res_l[SAMPLE_W]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg    <= '0;
         acc_l_reg   <= '0;
         acc_r_reg   <= '0;
         v_reg       <= '0;
         audio_left  <= '0;
         audio_right <= '0;
         out_valid   <= 1'b0;
      end else begin
         out_valid <= (state_reg == SCALE);
         case (state_reg)
            IDLE: begin
               if (start) begin
                  hold_reg  <= voice_in;
                  acc_l_reg <= '0;
                  acc_r_reg <= '0;
                  v_reg     <= '0;
               end
            end
            ACCUM: begin
               if (en_sel) begin
                  acc_l_reg <= acc_l_reg + ACC_W'(l_term);
                  acc_r_reg <= acc_r_reg + ACC_W'(r_term);
               end
               v_reg <= v_reg + 5'd1;
            end
            SCALE: begin
               audio_left  <= ctrl_reg[1] ? '0 : res_l[SAMPLE_W-1:0];
               audio_right <= ctrl_reg[1] ? '0 : res_r[SAMPLE_W-1:0];
            end
            default: ;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0], wr_dat_reg[30:25]};

endmodule

// File: doc/audio_mixer_seq.md
Name: audio_mixer_seq

Overview:
Parametrised next-generation stereo voice mixer. Each voice has its own gain, pan and enable. Voices are mixed by a time-multiplexed MAC that handles one voice per clock instead of a combinational adder tree, so NUM_VOICES scales without growing the multiplier count. The block sits between the voice generators and the I2S/DAC serializer, is configured over a Wishbone slave, and reports sticky clip and overrun status.

Parameters:
NUM_VOICES, 8, number of voice inputs (1..16)
SAMPLE_W, 16, signed sample width of voices and outputs
ACC_W, SAMPLE_W+6, signed accumulator width (must be >= SAMPLE_W+clog2(NUM_VOICES)+2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
sample_clk_en  in  1  one-cycle frame strobe
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; only [7:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
voice_in  in  NUM_VOICES*SAMPLE_W  packed signed voices; voice i = [i*SAMPLE_W +: SAMPLE_W]
audio_left  out  SAMPLE_W  signed left output
audio_right  out  SAMPLE_W  signed right output
out_valid  out  1  one-cycle pulse when new outputs are presented
busy  out  1  high while a frame is being mixed

Behaviour:
- One clock. Reset is asynchronous and active-low. Reset values: all outputs 0; CTRL=0x1; MASTER_VOL=0x8000; CLIP_MODE=1; STATUS=0. Every VOICE_CFG = gain 0x100, pan 0x080, enable 1. FSM in IDLE.
- Register map (wb_adr_i[7:2]):
  - 0x00 CTRL: [0] enable, [1] mute.
  - 0x04 MASTER_VOL: [15:0] unsigned; 0x8000 = unity.
  - 0x08 STATUS: [0] clip_l, [1] clip_r, [2] overrun. Sticky; write 1 to clear. Set wins over a clear in the same cycle.
  - 0x0C CLIP_MODE: [1:0]. 0 = wrap, 1 = saturate, 2/3 = force output 0.
  - 0x40+4*i VOICE_CFG i: [8:0] gain (Q1.8, 0x100 unity), [24:16] pan (0x000 full left, 0x100 full right; writes above 0x100 clamp to 0x100), [31] voice enable.
- Wishbone: wb_ack_o rises one cycle after cyc&stb and lasts one cycle; the next ack comes no sooner than two cycles later. The write commits on the ack cycle. Read data is registered on the request cycle. Unmapped addresses and voice index >= NUM_VOICES read 0xDEADBEEF; writes to them are ignored.
- FSM: IDLE -> ACCUM -> SCALE -> OUT -> IDLE.
  - IDLE: sample_clk_en with enable=1 snapshots voice_in into a holding register, clears both accumulators, sets voice index v=0 and moves to ACCUM. With enable=0 the strobe is ignored and outputs hold.
  - ACCUM: one cycle per voice, v = 0..NUM_VOICES-1. For an enabled voice: p = (s*gain)>>>8, L += (p*(0x100-pan))>>>8, R += (p*pan)>>>8. Shifts are arithmetic (floor). A disabled voice adds 0. VOICE_CFG is read live, so a write mid-frame affects only voices not yet processed.
  - SCALE: y = (acc*MASTER_VOL)>>>15 per channel. Apply CLIP_MODE: wrap takes the low SAMPLE_W bits; saturate clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and sets clip_l/clip_r when clamping occurs. If mute=1, force 0 and do not set clip bits.
  - OUT: register the outputs, pulse out_valid for one cycle, return to IDLE.
- Latency: out_valid is high exactly NUM_VOICES+2 cycles after the sample_clk_en cycle. busy is high from the cycle after the strobe through the OUT cycle.
- sample_clk_en while busy: strobe dropped, current frame unaffected, overrun set. A strobe in the same cycle as OUT is also an overrun; the next frame can start from IDLE the following cycle.
- Clearing enable mid-frame does not abort the frame; the frame completes.
- Outputs hold their last value between out_valid pulses.
- Reset mid-frame returns the FSM to IDLE with outputs 0 and no out_valid.

Test Plan:
- NUM_VOICES=8, voice0=0x4000, voices 1-7 disabled, gain 0x100, pan 0x000, master 0x8000; pulse sample_clk_en -> out_valid exactly 10 cycles later, left=0x4000, right=0x0000.
- Same stimulus with pan 0x080 -> left=0x2000, right=0x2000. With pan 0x100 -> left=0x0000, right=0x4000.
- Voices 0-3 = 0x7FFF, gain 0x100, pan 0x000, saturate mode -> left=0x7FFF, STATUS=0x1. Then write STATUS=0x1 -> reads 0x0. Wrap mode, same stimulus -> left=0xFFFC, clip bits stay 0.
- Second sample_clk_en 3 cycles after the first -> single out_valid, STATUS[2]=1, outputs equal the first frame's result.
- mute=1 with voice0=0x4000 -> out_valid still pulses, left=right=0. Read of 0x40+4*8 -> 0xDEADBEEF. Write pan 0x1FF -> reads back 0x100.
- Assert rst_n low at cycle 5 of a frame -> outputs 0, busy 0, no out_valid, registers at reset values.
